axi4_lite_slave_ctrl: RTL and testbench
=======================================

# axi4_lite_slave_ctrl

AXI4-Lite slave protocol engine that sits directly upstream of the register file. It terminates the five AXI4-Lite channels and turns each accepted write or read into a single-cycle request on the register file's write/read interface. It then returns the register file's data and response on the B/R channels. Write and read paths are independent and may be active in the same cycle.

## Interface
- ADDR_WIDTH, 32, AXI and register-file address width (byte address)
- DATA_WIDTH, 32, data width; only 32 is supported
- NUM_REGS, 16, number of 32-bit registers behind the block; defines the legal address window 0 .. NUM_REGS*4-1
- clk  in  1  single clock; everything is synchronous to its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- wr_addr, wr_data, wr_strb, wr_en  out  ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8, 1  register-file write request
- wr_resp  in  2  register-file write response
- rd_addr, rd_en  out  ADDR_WIDTH, 1  register-file read request
- rd_data, rd_resp  in  DATA_WIDTH, 2  register-file combinational read return

## Operation
- **Write FSM states:** W_IDLE, W_EXEC, W_RESP.
- **W_IDLE:**
  - awready=1 while no address is held; wready=1 while no data is held.
  - AW and W are accepted independently, in either order or in the same cycle. The accepted value is held in local registers.
  - Once both address and data are held, the FSM moves to W_EXEC.
- **W_EXEC (exactly one cycle):**
  - Drive wr_addr, wr_data and wr_strb from the held registers.
  - If the address is in range (awaddr < NUM_REGS*4): wr_en=1, and bresp is captured from wr_resp at the end of the cycle.
  - If the address is out of range: wr_en=0 and bresp=2'b10 (SLVERR).
  - Clear both held flags, set bvalid=1, go to W_RESP.
- **W_RESP:** hold bvalid and bresp stable until the bready handshake, then bvalid=0 and return to W_IDLE.
- **Read FSM states:** R_IDLE, R_EXEC, R_RESP.
- **R_IDLE:** arready=1. On the AR handshake, capture araddr and go to R_EXEC.
- **R_EXEC (exactly one cycle):**
  - Drive rd_addr from the captured address.
  - If the address is in range: rd_en=1, and rdata/rresp are registered from rd_data/rd_resp.
  - If the address is out of range: rd_en=0, rdata=0, rresp=2'b10.
  - Set rvalid=1, go to R_RESP.
- **R_RESP:** hold rvalid, rdata and rresp stable until the rready handshake, then return to R_IDLE.
- **Address handling:** low two address bits are ignored; the address is passed through unmodified to the register file.
- **Simultaneous read and write to the same register:** both EXEC cycles coincide and the read returns the pre-write value.
- **No outstanding transactions:** a new AW/W is not accepted until B completes; a new AR is not accepted until R completes.
- **Valid-before-ready:** AXI valid-before-ready rules are honoured; ready never depends combinationally on valid.

## Timing
- **Reset values:** awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_en=0, rd_en=0, wr_addr/wr_data/wr_strb/rd_addr=0.
- **After reset:** readies rise on the first clock edge after rst_n deasserts.
- **Write latency:** AW and W handshakes at edge N (simultaneously) → wr_en high during cycle N..N+1 → bvalid high from edge N+1.
- **AW and W at different edges:** latency counts from the later handshake.
- **Read latency:** AR handshake at edge N → rd_en high during cycle N..N+1 → rvalid high from edge N+1.
- **Response back-pressure:** bready/rready held low stalls the FSM in W_RESP/R_RESP indefinitely with outputs stable.
- **Minimum period:** 3 cycles per write and 3 cycles per read with ready held high.
- **Reset mid-transaction:** pending and held transactions are dropped, all outputs go to reset values immediately (asynchronously), and no wr_en pulse is produced.

## Test plan
- AW+W same cycle, addr 0x08, data 0xDEADBEEF, strb 0xF, bready=1 → one wr_en pulse with wr_addr=0x08; bvalid one edge later, bresp=2'b00.
- W issued 3 cycles before AW (addr 0x0C, strb 0x3, data 0x1234ABCD); read 0x0C afterwards → rdata=0x0000ABCD, rresp=2'b00.
- Read addr 0x40 with NUM_REGS=16 → rd_en never asserted, rdata=0, rresp=2'b10. Write to 0x44 → wr_en never asserted, bresp=2'b10.
- rready held low 10 cycles after the read of 0x04 → rvalid and rdata stable, arready=0 throughout; completes when rready rises.
- Concurrent write 0x55AA55AA and read of the same address 0x10 (previously 0) → read returns 0; a second read returns 0x55AA55AA.
- rst_n pulsed low while in W_RESP with bready=0 → bvalid drops immediately. After release, the next write completes normally and no extra wr_en pulse occurs.

Source files
------------

// File: rtl/axi4_lite_slave_ctrl_if.sv
// AXI4-Lite bus bundle between an AXI master and axi4_lite_slave_ctrl.
interface axi4_lite_slave_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi4_lite_slave_ctrl.sv
// AXI4-Lite slave engine: turns each accepted write/read into a one-cycle
// register-file request and returns the result on B/R. Read and write paths are independent.
module axi4_lite_slave_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axi4_lite_slave_ctrl_if.slave   axi,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic [DATA_WIDTH/8-1:0] wr_strb_o,
  output logic                    wr_en_o,
  input  logic [1:0]              wr_resp_i,
  output logic [ADDR_WIDTH-1:0]   rd_addr_o,
  output logic                    rd_en_o,
  input  logic [DATA_WIDTH-1:0]   rd_data_i,
  input  logic [1:0]              rd_resp_i
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_e;

  w_state_e              w_state_q;
  logic                  aw_held_q, w_held_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, wr_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data_q;
  logic [STRB_WIDTH-1:0] wstrb_q, wr_strb_q;
  logic                  wr_en_q;

  r_state_e              r_state_q;
  logic                  arready_q, rvalid_q, rd_en_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, aw_have, w_have, ar_hs;
  logic [ADDR_WIDTH-1:0] awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_d;

  // Readies are only ever high in the IDLE states, so handshakes imply IDLE.
  assign aw_hs    = axi.s_axi_awvalid & awready_q;
  assign w_hs     = axi.s_axi_wvalid & wready_q;
  assign ar_hs    = axi.s_axi_arvalid & arready_q;
  assign aw_have  = aw_held_q | aw_hs;
  assign w_have   = w_held_q | w_hs;
  assign awaddr_d = aw_hs ? axi.s_axi_awaddr : awaddr_q;
  assign wdata_d  = w_hs ? axi.s_axi_wdata : wdata_q;
  assign wstrb_d  = w_hs ? axi.s_axi_wstrb : wstrb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= axi.s_axi_awaddr;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= axi.s_axi_wdata;
            wstrb_q  <= axi.s_axi_wstrb;
          end
          if (aw_have && w_have) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_addr_q <= awaddr_d;
            wr_data_q <= wdata_d;
            wr_strb_q <= wstrb_d;
            wr_en_q   <= (awaddr_d < ADDR_LIMIT);
            w_state_q <= W_EXEC;
          end else begin
            awready_q <= ~aw_have;
            wready_q  <= ~w_have;
          end
        end
        W_EXEC: begin
          // wr_en_q doubles as the in-range flag for this transaction.
          wr_en_q   <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_en_q ? wr_resp_i : RESP_SLVERR;
          w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (axi.s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rd_addr_q <= axi.s_axi_araddr;
            rd_en_q   <= (axi.s_axi_araddr < ADDR_LIMIT);
            r_state_q <= R_EXEC;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_EXEC: begin
          rd_en_q   <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_en_q ? rd_data_i : '0;
          rresp_q   <= rd_en_q ? rd_resp_i : RESP_SLVERR;
          r_state_q <= R_RESP;
        end
        R_RESP: begin
          if (axi.s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign axi.s_axi_awready = awready_q;
  assign axi.s_axi_wready  = wready_q;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign wr_addr_o         = wr_addr_q;
  assign wr_data_o         = wr_data_q;
  assign wr_strb_o         = wr_strb_q;
  assign wr_en_o           = wr_en_q;
  assign rd_addr_o         = rd_addr_q;
  assign rd_en_o           = rd_en_q;
endmodule

// File: tb/tb_axi4_lite_slave_ctrl.sv
// Directed plus randomized bench for axi4_lite_slave_ctrl against a word-array
// model of the register file contents and the expected AXI responses.
module tb_axi4_lite_slave_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_slave_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] wr_addr_o, rd_addr_o;
  logic [DW-1:0] wr_data_o, rd_data_i;
  logic [3:0]    wr_strb_o;
  logic          wr_en_o, rd_en_o;
  logic [1:0]    wr_resp_i, rd_resp_i;

  axi4_lite_slave_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axi       (bus.slave),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .wr_strb_o (wr_strb_o),
    .wr_en_o   (wr_en_o),
    .wr_resp_i (wr_resp_i),
    .rd_addr_o (rd_addr_o),
    .rd_en_o   (rd_en_o),
    .rd_data_i (rd_data_i),
    .rd_resp_i (rd_resp_i)
  );

  // Simple register file attached to the DUT; reads alias on the low index bits.
  logic [31:0] rf_mem [NR] = '{default: '0};
  logic [1:0]  rf_wresp = 2'b00;
  logic [1:0]  rf_rresp = 2'b00;
  int          wr_pulses = 0;

  always @(posedge clk) begin
    if (wr_en_o) begin
      wr_pulses <= wr_pulses + 1;
      for (int b = 0; b < 4; b++)
        if (wr_strb_o[b]) rf_mem[wr_addr_o[5:2]][8*b +: 8] <= wr_data_o[8*b +: 8];
    end
  end
  assign rd_data_i = rf_mem[rd_addr_o[5:2]];
  assign rd_resp_i = rf_rresp;
  assign wr_resp_i = rf_wresp;

  // Reference model state
  logic [31:0] exp_mem [NR];
  int          exp_pulses = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [3:0] idx;
    idx = addr[5:2];
    if (addr < NR * 4) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) exp_mem[idx][8*b +: 8] = data[8*b +: 8];
      exp_pulses++;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_now, w_now, inr;
    int cyc;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; cyc = 0;
    inr = (addr < NR * 4);
    exp_resp = inr ? rf_wresp : 2'b10;
    bus.s_axi_awaddr = addr;
    bus.s_axi_wdata  = data;
    bus.s_axi_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      bus.s_axi_wvalid  = !w_done && (cyc >= w_dly);
      aw_now = bus.s_axi_awvalid && bus.s_axi_awready;
      w_now  = bus.s_axi_wvalid && bus.s_axi_wready;
      step();
      aw_done |= aw_now;
      w_done  |= w_now;
      cyc++;
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    check("wr_handshake", aw_done && w_done, 1);
    check("wr_en", wr_en_o, inr);
    if (inr) begin
      check("wr_addr", wr_addr_o, addr);
      check("wr_data", wr_data_o, data);
      check("wr_strb", wr_strb_o, strb);
    end
    check("awready_busy", bus.s_axi_awready, 0);
    model_write(addr, data, strb);
    step();
    check("bvalid_latency", bus.s_axi_bvalid, 1);
    check("wr_en_single", wr_en_o, 0);
    check("bresp", bus.s_axi_bresp, exp_resp);
    for (int i = 0; i < b_dly; i++) begin
      step();
      check("bvalid_hold", bus.s_axi_bvalid, 1);
      check("bresp_hold", bus.s_axi_bresp, exp_resp);
    end
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    check("bvalid_clear", bus.s_axi_bvalid, 0);
    check("awready_back", bus.s_axi_awready, 1);
    check("wr_pulses", wr_pulses, exp_pulses);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly, output logic [31:0] data);
    bit done, now, inr;
    int cyc;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [3:0]  idx;
    done = 0; cyc = 0;
    idx = addr[5:2];
    inr = (addr < NR * 4);
    exp_data = inr ? exp_mem[idx] : 32'h0;
    exp_resp = inr ? rf_rresp : 2'b10;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    while (!done && cyc < 50) begin
      now = bus.s_axi_arready;
      step();
      done = now;
      cyc++;
    end
    bus.s_axi_arvalid = 1'b0;
    check("ar_handshake", done, 1);
    check("rd_en", rd_en_o, inr);
    if (inr) check("rd_addr", rd_addr_o, addr);
    step();
    check("rvalid_latency", bus.s_axi_rvalid, 1);
    check("rd_en_single", rd_en_o, 0);
    check("rdata", bus.s_axi_rdata, exp_data);
    check("rresp", bus.s_axi_rresp, exp_resp);
    data = bus.s_axi_rdata;
    for (int i = 0; i < r_dly; i++) begin
      step();
      check("rvalid_hold", bus.s_axi_rvalid, 1);
      check("rdata_hold", bus.s_axi_rdata, exp_data);
      check("arready_stall", bus.s_axi_arready, 0);
    end
    bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0;
    check("rvalid_clear", bus.s_axi_rvalid, 0);
    check("arready_back", bus.s_axi_arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] d, a, old;
    int r;
    for (int i = 0; i < NR; i++) exp_mem[i] = 32'h0;
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;

    // Reset state and ready rise
    #1;
    check("rst_awready", bus.s_axi_awready, 0);
    check("rst_bvalid", bus.s_axi_bvalid, 0);
    check("rst_rvalid", bus.s_axi_rvalid, 0);
    check("rst_rdata", bus.s_axi_rdata, 0);
    check("rst_wr_en", wr_en_o, 0);
    step(); step();
    rst_n = 1'b1;
    check("release_arready", bus.s_axi_arready, 0);
    step();
    check("ready_aw", bus.s_axi_awready, 1);
    check("ready_w", bus.s_axi_wready, 1);
    check("ready_ar", bus.s_axi_arready, 1);

    // Same-cycle AW/W
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    // W three cycles ahead of AW, then partial-strobe readback
    axi_write(32'h0C, 32'h1234ABCD, 4'h3, 3, 0, 0);
    axi_read(32'h0C, 0, d);
    check("tp2_rdata", d, 32'h0000ABCD);
    // Out-of-range accesses
    axi_read(32'h40, 0, d);
    check("tp3_rdata", d, 32'h0);
    check("tp3_rresp", bus.s_axi_rresp, 2'b10);
    axi_write(32'h44, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    check("tp3_bresp", bus.s_axi_bresp, 2'b10);
    // Read back-pressure
    axi_read(32'h04, 10, d);

    // Concurrent write and read of 0x10
    old = exp_mem[4];
    bus.s_axi_awaddr = 32'h10; bus.s_axi_wdata = 32'h55AA55AA; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_araddr = 32'h10;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    check("tp5_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    check("tp5_exec", {wr_en_o, rd_en_o}, 2'b11);
    model_write(32'h10, 32'h55AA55AA, 4'hF);
    step();
    check("tp5_valids", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b11);
    check("tp5_first_read", bus.s_axi_rdata, old);
    check("tp5_first_zero", bus.s_axi_rdata, 32'h0);
    bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    check("tp5_done", {bus.s_axi_bvalid, bus.s_axi_rvalid}, 2'b00);
    axi_read(32'h10, 0, d);
    check("tp5_second_read", d, 32'h55AA55AA);

    // Reset while parked in the write response phase
    bus.s_axi_awaddr = 32'h18; bus.s_axi_wdata = 32'hA5A5_0F0F; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    model_write(32'h18, 32'hA5A5_0F0F, 4'hF);
    step(); step(); step();
    check("tp6_bvalid_parked", bus.s_axi_bvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("tp6_bvalid_async", bus.s_axi_bvalid, 0);
    check("tp6_awready_async", bus.s_axi_awready, 0);
    check("tp6_wr_en_async", wr_en_o, 0);
    step();
    rst_n = 1'b1;
    step();
    check("tp6_pulses", wr_pulses, exp_pulses);
    axi_write(32'h1C, 32'h0BAD_F00D, 4'hF, 1, 0, 2);
    axi_read(32'h1C, 0, d);
    check("tp6_readback", d, 32'h0BAD_F00D);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom | 32'h100;
      else if (r <= 2) a = $urandom_range(64, 79);
      else             a = $urandom_range(0, 63);
      rf_wresp = 2'($urandom_range(0, 1));
      rf_rresp = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3), d);
    end
    check("total_pulses", wr_pulses, exp_pulses);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
